shift_cmd_seq: RTL
==================

// Module: shift_cmd_seq
// PURPOSE
//   Upstream sequencer for the combinational barrel shifter (test1). Buffers shift commands in a FIFO.
//   Issues one command at a time on registered sh_* outputs and samples sh_dout after a settle delay.
//   Returns each result on a valid/ready port. Replaces hand-timed stimulus with a handshaked command stream.
// PARAMETERS
//   DEPTH   4  command FIFO entries; power of 2, >=2
//   SETTLE  1  cycles sh_* are held before sh_dout is sampled; 1..15
// PORTS
//   clk         in   1  single clock, all logic on posedge
//   rst         in   1  synchronous, active-high reset
//   cmd_valid   in   1  command offered
//   cmd_ready   out  1  FIFO can accept (count < DEPTH)
//   cmd_din     in   8  operand
//   cmd_shamt   in   3  shift amount 0..7
//   cmd_l_or_r  in   1  1=left, 0=right
//   cmd_a_or_l  in   1  1=arithmetic, 0=logical
//   sh_din      out  8  to shifter din (registered)
//   sh_shamt    out  3  to shifter shamt (registered)
//   sh_l_or_r   out  1  to shifter l_or_r (registered)
//   sh_a_or_l   out  1  to shifter a_or_l (registered)
//   sh_dout     in   8  from shifter dout (combinational)
//   res_valid   out  1  result available
//   res_ready   in   1  consumer takes result
//   res_data    out  8  captured sh_dout
//   busy        out  1  state != IDLE or FIFO non-empty
//   done_cnt    out  8  results delivered; wraps 255->0
// BEHAVIOUR
//   Reset: state=IDLE, FIFO pointers/count=0, sh_*=0, res_valid=0, res_data=0, done_cnt=0; cmd_ready=1 next cycle.
//   Reset mid-operation: flushes FIFO and any pending result; no partial result is emitted.
//   FIFO: push on cmd_valid&&cmd_ready; pop only in IDLE when count>0.
//     Pointers wrap modulo DEPTH. Push+pop on the same edge: count unchanged.
//     cmd_ready = (count<DEPTH), not pop-aware; it is 0 when full even if a pop occurs that cycle.
//     cmd_valid while !cmd_ready is ignored. FIFO contents are unchanged by that cycle.
//   FSM:
//     IDLE:  count>0 -> load sh_* from head, pop, settle_cnt=SETTLE, -> WAIT; else stay.
//     WAIT:  settle_cnt-- each cycle. When settle_cnt==1: res_data<=sh_dout, res_valid<=1, -> RESP.
//     RESP:  res_valid&&res_ready -> res_valid<=0, done_cnt++, -> IDLE; else hold res_data/res_valid.
//   sh_* hold their last issued values outside IDLE-pop edges; they are never cleared except by reset.
//   Latency: cmd accepted at edge E0 into empty idle block -> sh_* valid after E0+1.
//     res_valid=1 after edge E0+1+SETTLE (default 2 cycles).
//   Throughput with res_ready tied 1: one result per SETTLE+2 cycles.
//   res_data/res_valid are stable while res_valid&&!res_ready (no drop, no overwrite).
//   Results are delivered in command order, one per accepted command.
// TESTING (bench wires sh_* to a test1 instance)
//   1) 0xAA,sh5,right,logical -> res_data=0x05; 0xAA,sh3,right,arith -> 0xF5.
//      0xAA,sh2,left -> 0xA8; 0xAA,sh7,left -> 0x00; results in order; done_cnt=4.
//   2) res_ready=0, push 5 cmds back-to-back (DEPTH=4) -> cmd_ready=0 after 4th-in-FIFO.
//      5th held by bench until ready; res_data stable while stalled.
//   3) Latency: single cmd into idle block, res_ready=1 -> res_valid rises exactly 2 cycles after accept edge;
//      repeat with SETTLE=3 -> 4 cycles.
//   4) Full FIFO, simultaneous IDLE pop and cmd_valid -> push refused that cycle (cmd_ready=0).
//      Accepted next cycle; count never exceeds DEPTH.
//   5) rst asserted in WAIT with 3 queued cmds -> next cycle res_valid=0, busy=0, done_cnt=0, sh_*=0.
//      No stale results after release.
//   6) 256 commands with res_ready=1 -> done_cnt wraps to 0; pointer wrap verified by in-order data.

Source files
------------

// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: FIFO-buffered command sequencer for a combinational barrel shifter.
// Issues one command at a time on registered sh_* outputs and returns each sampled result on valid/ready.
module shift_cmd_seq #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_din_i,
  input  logic [2:0] cmd_shamt_i,
  input  logic       cmd_l_or_r_i,
  input  logic       cmd_a_or_l_i,
  output logic [7:0] sh_din_o,
  output logic [2:0] sh_shamt_o,
  output logic       sh_l_or_r_o,
  output logic       sh_a_or_l_o,
  input  logic [7:0] sh_dout_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] res_data_o,
  output logic       busy_o,
  output logic [7:0] done_cnt_o
);
  // state | meaning
  // IDLE  | waiting for a queued command; pops the FIFO head when one is present
  // WAIT  | sh_* driven, counting down the shifter settle time
  // RESP  | result held on res_* until the consumer accepts it
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      settle_q, settle_d;
  logic [7:0]      sh_din_q, sh_din_d;
  logic [2:0]      sh_shamt_q, sh_shamt_d;
  logic            sh_l_or_r_q, sh_l_or_r_d;
  logic            sh_a_or_l_q, sh_a_or_l_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_data_q, res_data_d;
  logic [7:0]      done_cnt_q, done_cnt_d;
  logic [12:0]     mem_q [DEPTH];
  logic [12:0]     head;
  logic            push, pop;

  // cmd_ready deliberately ignores a same-cycle pop
  assign cmd_ready_o = (count_q < DEPTH_C);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign head        = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= {cmd_a_or_l_i, cmd_l_or_r_i, cmd_shamt_i, cmd_din_i};
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    settle_d    = settle_q;
    sh_din_d    = sh_din_q;
    sh_shamt_d  = sh_shamt_q;
    sh_l_or_r_d = sh_l_or_r_q;
    sh_a_or_l_d = sh_a_or_l_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    done_cnt_d  = done_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sh_din_d    = head[7:0];
          sh_shamt_d  = head[10:8];
          sh_l_or_r_d = head[11];
          sh_a_or_l_d = head[12];
          settle_d    = SETTLE_C;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == 4'd1) begin
          res_data_d  = sh_dout_i;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      settle_q    <= '0;
      sh_din_q    <= '0;
      sh_shamt_q  <= '0;
      sh_l_or_r_q <= 1'b0;
      sh_a_or_l_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      sh_din_q    <= sh_din_d;
      sh_shamt_q  <= sh_shamt_d;
      sh_l_or_r_q <= sh_l_or_r_d;
      sh_a_or_l_q <= sh_a_or_l_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign sh_din_o    = sh_din_q;
  assign sh_shamt_o  = sh_shamt_q;
  assign sh_l_or_r_o = sh_l_or_r_q;
  assign sh_a_or_l_o = sh_a_or_l_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign done_cnt_o  = done_cnt_q;
  assign busy_o      = (state_q != S_IDLE) || (count_q != '0);
endmodule
